daq_tx_scheduler: RTL and testbench
===================================

# daq_tx_scheduler

Frames DAQ samples from several channels and sequences them onto the single shared UART transmitter. Each channel offers a 16-bit sample through a valid/ready handshake. A round-robin arbiter picks one channel, and the block emits a fixed 5-byte frame (sync, channel id, sample MSB, sample LSB, XOR checksum) one byte at a time, using the transmitter's start/busy handshake. It sits between the acquisition front-end and the UART transmitter.

## Interface
- NUM_CH, 4: number of requesting channels (1..16).
- SYNC_BYTE, 8'hA5: first byte of every frame.
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NUM_CH  per-channel sample available.
- req_data  in  16*NUM_CH  channel i sample at [16*i+15:16*i].
- req_ready  out  NUM_CH  one-hot grant; transfer when valid&ready.
- tx_start  out  1  one-cycle start pulse to the UART transmitter.
- tx_data  out  8  byte to transmit.
- tx_busy  in  1  transmitter busy flag.
- frame_active  out  1  high from sample accept until frame_done.
- frame_done  out  1  one-cycle pulse after the last byte completes.

## Operation
- States are IDLE, SEND, WAIT_HI and WAIT_LO.
- **IDLE**
  - req_ready is asserted (combinationally from req_valid) for exactly one channel: the first valid channel found searching upward, with wrap, from rr_ptr+1.
  - On transfer:
    - latch the channel id and sample;
    - set the checksum to SYNC_BYTE ^ {4'b0,id} ^ msb ^ lsb;
    - set rr_ptr to id and byte_idx to 0;
    - go to SEND.
  - With no valid channel, stay in IDLE.
- **SEND**
  - tx_data = frame[byte_idx], where frame = {SYNC_BYTE, {4'b0,id}, msb, lsb, checksum}.
  - If tx_busy=0, pulse tx_start and go to WAIT_HI.
  - If tx_busy=1, hold in SEND without pulsing.
- **WAIT_HI**: stay until tx_busy=1, then go to WAIT_LO.
- **WAIT_LO**: stay until tx_busy=0.
  - If byte_idx<4: increment byte_idx and go to SEND.
  - If byte_idx=4: pulse frame_done and go to IDLE.
- req_ready is 0 in every state except IDLE. Channels must hold valid and data stable until they are granted.
- req_valid must not depend combinationally on req_ready.
- **Reset values**:
  - tx_start=0, tx_data=8'h00, req_ready=0, frame_active=0, frame_done=0;
  - state=IDLE, byte_idx=0, rr_ptr=NUM_CH-1, so ch0 has first priority.
- **Reset mid-frame**: the partial frame is abandoned and is not resumed. The accepted sample is lost.
- **Simultaneous requests**: only the single grant transfers. Other channels keep valid high and wait.
- **rr_ptr wrap**: rr_ptr = NUM_CH-1 wraps the search to channel 0.
- **New valid during a frame**: ignored until IDLE.

## Timing
- Accept at cycle T (IDLE, valid&ready); frame_active=1 from T+1.
- First tx_start occurs at T+1 if tx_busy=0.
- tx_data is registered and stable from SEND entry through WAIT_LO exit.
- tx_data changes only on SEND entry.
- tx_start is high for exactly one cycle per byte, always with tx_busy=0 in that cycle. There are exactly 5 pulses per frame.
- Byte-to-byte gap: at most 2 cycles from tx_busy falling to the next tx_start (WAIT_LO→SEND→pulse).
- The transmitter's busy may rise one or more cycles after start; WAIT_HI tolerates any latency.
- frame_done occurs in the cycle after tx_busy falls for byte 4. frame_active falls in the same cycle.
- A new accept is possible in the following cycle (IDLE).
- Back-to-back frames: minimum 1 IDLE cycle between frame_done and the next accept.

## Structure
- Shared package daq_pkg holds:
  - FRAME_LEN=5;
  - default SYNC_BYTE;
  - the state encoding (IDLE, SEND, WAIT_HI, WAIT_LO; 2-bit);
  - the sample width (16).
- Sub-module rr_arbiter (NUM_CH; inputs req, ptr; outputs one-hot grant and binary id) is natural and reused by later DAQ muxes.
- The scheduler holds the FSM, frame registers, checksum and byte counter. Width rules:
  - byte_idx is 3 bits;
  - id is $clog2(NUM_CH) bits, zero-extended to 8 bits in the frame.

## Test plan
- **Single channel**: ch2 valid, data 16'h1234, UART model busy 1 cycle after start for 20 cycles.
  - tx bytes must be A5,02,12,34,81.
  - One frame_done; req_ready[2] high for exactly 1 cycle.
- **All-ones sample**: ch1, data 16'hFFFF → bytes A5,01,FF,FF,A4.
- **Round robin**: after reset, ch0 and ch3 held valid continuously → frames with ids 0,3,0,3. No channel is granted twice in a row while the other is waiting.
- **Busy-latency robustness**: busy rises 3 cycles after start and the transmitter is already busy when the block enters SEND.
  - No tx_start while tx_busy=1.
  - Exactly 5 start pulses.
  - tx_data never changes while busy.
- **Reset mid-frame**: rst asserted during byte 2.
  - Next cycle: state IDLE, tx_start=0, frame_active=0, tx_data=00.
  - The next frame starts with A5 from ch0 priority.
- **Hold-off**: a valid raised on ch3 during a ch0 frame gets req_ready[3]=0 until IDLE. The ch3 frame then follows with its data intact.

Source files
------------

// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ framing blocks.
//   SAMPLE_W          : width of one channel sample
//   FRAME_LEN         : bytes per frame (sync, id, msb, lsb, checksum)
//   DEFAULT_SYNC_BYTE : first byte of every frame unless overridden
//   LAST_BYTE_IDX     : byte_idx value of the checksum byte
//   tx_state_t        : scheduler FSM encoding
//   id_width()        : channel id width, at least 1 bit
package daq_pkg;

    localparam int         SAMPLE_W          = 16;
    localparam int         FRAME_LEN         = 5;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam logic [2:0] LAST_BYTE_IDX     = 3'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } tx_state_t;

    // A single-channel build still needs a 1-bit id field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request searching upward,
// with wrap, starting one position above ptr.
//   req   in  NUM_CH  request vector
//   ptr   in  ID_W    last granted channel
//   grant out NUM_CH  one-hot grant (all zero when no request)
//   id    out ID_W    binary index of the granted channel
module rr_arbiter
    import daq_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int ID_W  = id_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [ID_W-1:0]   id
);

    logic found;
    int   idx;

    // Offset 1 is the channel just above ptr; offset NUM_CH is ptr itself,
    // so the last granted channel only wins again when it is alone.
    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                id         = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/daq_tx_scheduler.sv
// Frames one channel sample at a time into a 5-byte packet
// (sync, id, msb, lsb, xor checksum) and feeds it byte by byte to a UART
// transmitter through a start/busy handshake.
//   clk, rst      : clock, synchronous active-high reset
//   req_valid     : per-channel sample available
//   req_data      : channel i sample at [16*i+15:16*i]
//   req_ready     : one-hot grant, only while idle
//   tx_start      : one-cycle start pulse, only while tx_busy is low
//   tx_data       : registered byte to transmit
//   tx_busy       : transmitter busy flag
//   frame_active  : high from sample accept until frame_done
//   frame_done    : one-cycle pulse after the last byte completes
module daq_tx_scheduler
    import daq_pkg::*;
#(
    parameter int         NUM_CH    = 4,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req_valid,
    input  logic [SAMPLE_W*NUM_CH-1:0] req_data,
    output logic [NUM_CH-1:0]          req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic                       frame_active,
    output logic                       frame_done
);

    localparam int ID_W = id_width(NUM_CH);

    tx_state_t             state;
    logic [2:0]            byte_idx;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       id;
    logic [7:0]            msb;
    logic [7:0]            lsb;
    logic [7:0]            checksum;
    logic [NUM_CH-1:0]     grant;
    logic [ID_W-1:0]       grant_id;
    logic [SAMPLE_W-1:0]   sel_sample;
    logic [7:0]            next_byte;
    logic                  accept;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .id    (grant_id)
    );

    // Grant and start are combinational so a transfer lands in the same cycle
    // the condition is seen, and a start can never coincide with busy.
    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign tx_start  = (state == SEND) && !tx_busy && !rst;

    always_comb begin
        sel_sample = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_sample = req_data[i*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    // Byte to load when leaving WAIT_LO with the current byte_idx; the sync
    // byte is loaded directly on accept.
    always_comb begin
        case (byte_idx)
            3'd0:    next_byte = 8'(id);
            3'd1:    next_byte = msb;
            3'd2:    next_byte = lsb;
            default: next_byte = checksum;
        endcase
    end

    // tx_data is only written on SEND entry, so it stays put for the whole
    // start/busy exchange of each byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            byte_idx     <= '0;
            rr_ptr       <= ID_W'(NUM_CH - 1);
            id           <= '0;
            msb          <= '0;
            lsb          <= '0;
            checksum     <= '0;
            tx_data      <= 8'h00;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        id           <= grant_id;
                        msb          <= sel_sample[15:8];
                        lsb          <= sel_sample[7:0];
                        checksum     <= SYNC_BYTE ^ 8'(grant_id)
                                        ^ sel_sample[15:8] ^ sel_sample[7:0];
                        rr_ptr       <= grant_id;
                        byte_idx     <= '0;
                        tx_data      <= SYNC_BYTE;
                        frame_active <= 1'b1;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        state <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (byte_idx < LAST_BYTE_IDX) begin
                            byte_idx <= byte_idx + 3'd1;
                            tx_data  <= next_byte;
                            state    <= SEND;
                        end else begin
                            frame_done   <= 1'b1;
                            frame_active <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_daq_tx_scheduler.sv
// Directed bench for daq_tx_scheduler with a small UART busy model whose
// start-to-busy latency and busy duration are adjustable per scenario.
module tb_daq_tx_scheduler;

    localparam int NUM_CH = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_CH-1:0]    req_valid = '0;
    logic [16*NUM_CH-1:0] req_data = '0;
    logic [NUM_CH-1:0]    req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy = 1'b0;
    logic                 frame_active;
    logic                 frame_done;

    int vectors = 0;
    int miscompares = 0;

    int   lat = 1;
    int   dur = 20;
    int   start_dly = 0;
    int   busy_cnt = 0;
    logic force_busy = 1'b0;

    logic [NUM_CH-1:0] drop_mask = '1;
    logic [NUM_CH-1:0] pend_drop = '0;

    logic [7:0] byte_q[$];
    int         grant_q[$];
    int         done_cnt = 0;
    int         start_cnt = 0;
    int         ready_cnt[NUM_CH];
    int         cyc = 0;
    int         grant_cyc = 0;
    int         fall_cyc = 0;
    int         frame_bytes = 0;
    int         first_lat = -1;
    logic       prev_busy = 1'b0;
    logic       prev_active = 1'b0;
    logic [7:0] prev_data = 8'h00;

    daq_tx_scheduler #(.NUM_CH(NUM_CH), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .frame_active (frame_active),
        .frame_done   (frame_done)
    );

    always #10 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Sampled at the falling edge, away from the DUT's active edge.
    task automatic observe();
        cyc++;
        check_output("ready_legal",
                     32'($onehot0(req_ready) && ((req_ready & ~req_valid) == '0)), 32'd1);
        if (tx_start) begin
            check_output("start_while_busy", 32'(tx_busy), 32'd0);
            if (frame_bytes == 0) first_lat = cyc - grant_cyc;
            else check_output("byte_gap", 32'((cyc - fall_cyc) <= 2), 32'd1);
            frame_bytes++;
            byte_q.push_back(tx_data);
            start_cnt++;
            start_dly = lat;
        end
        if (tx_busy && prev_busy && frame_active && prev_active)
            check_output("data_hold", 32'(tx_data), 32'(prev_data));
        if (prev_busy && !tx_busy) fall_cyc = cyc;
        if (frame_done) begin
            done_cnt++;
            check_output("done_after_fall", 32'(cyc - fall_cyc), 32'd1);
            check_output("active_at_done", 32'(frame_active), 32'd0);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_ready[i]) ready_cnt[i]++;
            if (req_valid[i] && req_ready[i]) begin
                grant_q.push_back(i);
                grant_cyc   = cyc;
                frame_bytes = 0;
                if (drop_mask[i]) pend_drop[i] = 1'b1;
            end
        end
        prev_busy   = tx_busy;
        prev_active = frame_active;
        prev_data   = tx_data;
    endtask

    // One clock: observe, then update the channel sources and busy model
    // just after the rising edge.
    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~pend_drop;
        pend_drop = '0;
        if (busy_cnt > 0) busy_cnt--;
        if (start_dly > 0) begin
            start_dly--;
            if (start_dly == 0) busy_cnt = dur;
        end
        tx_busy = force_busy || (busy_cnt > 0);
    endtask

    task automatic set_force(input logic b);
        force_busy = b;
        tx_busy    = force_busy || (busy_cnt > 0);
    endtask

    task automatic clear_logs();
        byte_q.delete();
        grant_q.delete();
        done_cnt  = 0;
        start_cnt = 0;
        first_lat = -1;
        foreach (ready_cnt[i]) ready_cnt[i] = 0;
    endtask

    task automatic reset_dut(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic run_frames(input int n, input int budget);
        int k = 0;
        while (done_cnt < n && k < budget) begin
            step();
            k++;
        end
        check_output("frame_count", 32'(done_cnt), 32'(n));
    endtask

    task automatic check_frame(input string tag, input int base, input logic [39:0] exp);
        logic [31:0] got;
        for (int k = 0; k < 5; k++) begin
            got = (base + k < byte_q.size()) ? 32'(byte_q[base + k]) : 32'hFFFF_FFFF;
            check_output($sformatf("%s_byte%0d", tag, k), got, 32'(exp[39 - 8*k -: 8]));
        end
    endtask

    task automatic check_grant(input string tag, input int idx, input int exp);
        logic [31:0] got;
        got = (idx < grant_q.size()) ? 32'(grant_q[idx]) : 32'hFFFF_FFFF;
        check_output(tag, got, 32'(exp));
    endtask

    initial begin
        int k;

        // Reset values, with every channel requesting.
        foreach (ready_cnt[i]) ready_cnt[i] = 0;
        req_valid = '1;
        repeat (2) step();
        #1;
        check_output("rst_tx_start", 32'(tx_start), 32'd0);
        check_output("rst_tx_data", 32'(tx_data), 32'h00);
        check_output("rst_req_ready", 32'(req_ready), 32'd0);
        check_output("rst_frame_active", 32'(frame_active), 32'd0);
        check_output("rst_frame_done", 32'(frame_done), 32'd0);
        req_valid = '0;
        rst = 1'b0;

        // Single channel 2, sample 1234.
        clear_logs();
        lat = 1;
        dur = 20;
        req_data[47:32] = 16'h1234;
        req_valid[2] = 1'b1;
        run_frames(1, 300);
        check_frame("ch2", 0, 40'hA5_02_12_34_81);
        check_output("ch2_starts", 32'(start_cnt), 32'd5);
        check_output("ch2_ready_cycles", 32'(ready_cnt[2]), 32'd1);
        check_output("ch2_first_start_lat", 32'(first_lat), 32'd1);
        check_grant("ch2_grant", 0, 2);

        // All-ones sample on channel 1.
        clear_logs();
        req_data[31:16] = 16'hFFFF;
        req_valid[1] = 1'b1;
        run_frames(1, 300);
        check_frame("ones", 0, 40'hA5_01_FF_FF_A4);
        check_grant("ones_grant", 0, 1);

        // Round robin between continuously requesting channels 0 and 3.
        reset_dut(2);
        clear_logs();
        dur = 3;
        drop_mask = 4'b0110;
        req_data[15:0]  = 16'h0A0B;
        req_data[63:48] = 16'h0C0D;
        req_valid = 4'b1001;
        run_frames(4, 400);
        req_valid = '0;
        drop_mask = '1;
        check_grant("rr_grant0", 0, 0);
        check_grant("rr_grant1", 1, 3);
        check_grant("rr_grant2", 2, 0);
        check_grant("rr_grant3", 3, 3);
        check_frame("rr_f0", 0, 40'hA5_00_0A_0B_A4);
        check_frame("rr_f1", 5, 40'hA5_03_0C_0D_A7);

        // Slow busy and a transmitter already busy on SEND entry.
        reset_dut(2);
        clear_logs();
        lat = 3;
        dur = 4;
        set_force(1'b1);
        req_data[31:16] = 16'h5A3C;
        req_valid[1] = 1'b1;
        repeat (4) step();
        check_output("lat_start_held", 32'(start_cnt), 32'd0);
        set_force(1'b0);
        run_frames(1, 300);
        check_frame("lat", 0, 40'hA5_01_5A_3C_C2);
        check_output("lat_starts", 32'(start_cnt), 32'd5);

        // Reset while byte 2 is in flight.
        clear_logs();
        lat = 1;
        dur = 6;
        req_data[47:32] = 16'hBEEF;
        req_valid[2] = 1'b1;
        k = 0;
        while (byte_q.size() < 3 && k < 200) begin
            step();
            k++;
        end
        check_output("mid_byte2_reached", 32'(byte_q.size() >= 3), 32'd1);
        rst = 1'b1;
        step();
        #1;
        check_output("mid_tx_data", 32'(tx_data), 32'h00);
        check_output("mid_frame_active", 32'(frame_active), 32'd0);
        rst = 1'b0;
        req_data[15:0]  = 16'h1122;
        req_data[63:48] = 16'h7788;
        req_valid = 4'b1001;
        #1;
        check_output("mid_ch0_priority", 32'(req_ready), 32'h1);
        check_output("mid_tx_start_idle", 32'(tx_start), 32'd0);

        // Channel 3 waits out the channel 0 frame, then sends intact data.
        clear_logs();
        run_frames(1, 300);
        check_frame("post_rst", 0, 40'hA5_00_11_22_96);
        check_grant("post_rst_grant", 0, 0);
        check_output("holdoff_ready3", 32'(ready_cnt[3]), 32'd1);
        run_frames(2, 300);
        check_frame("holdoff_ch3", 5, 40'hA5_03_77_88_59);
        check_grant("holdoff_grant", 1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
